// File: rtl/cdb_arbiter_pkg.sv
// ============================================================================
// cdb_arbiter_pkg : shared CDB widths, broadcast entry type and helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef CDB_DEFINES_SV
`define CDB_DEFINES_SV
`define REG_VAL_WIDTH          32
`define PHYSICAL_REG_NUM_WIDTH 6
`define ROB_SIZE_WIDTH         5
`define NUM_OF_ALUS            2
`define NUM_OF_MEM             2
`endif

package cdb_arbiter_pkg;

  localparam int unsigned CDB_NUM_REQ = `NUM_OF_ALUS + `NUM_OF_MEM;
  localparam int unsigned CDB_SRC_W   = $clog2(CDB_NUM_REQ);

  typedef struct packed {
    logic [`PHYSICAL_REG_NUM_WIDTH-1:0] dst_reg;
    logic [`REG_VAL_WIDTH-1:0]          val;
    logic [`ROB_SIZE_WIDTH-1:0]         tag;
    logic [CDB_SRC_W-1:0]               src;
  } cdb_entry_t;

  // Explicit wrap so non-power-of-two requester counts rotate correctly.
  function automatic int unsigned rr_wrap_inc(input int unsigned idx,
                                              input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_rr_priority_picker.sv
// ============================================================================
// rr_priority_picker : first set request at or after ptr, wrapping modulo N
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_priority_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int unsigned pos;
    logic [IW-1:0] p;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(ptr_i) + k;
      if (pos >= N) pos = pos - N;
      p = IW'(pos);
      if (!any_o && req_i[p]) begin
        any_o    = 1'b1;
        idx_o    = p;
        gnt_o[p] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// cdb_arbiter : round-robin arbiter of FU results onto the registered CDB
// Revision: 1.0
// ============================================================================
`default_nettype none

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = CDB_NUM_REQ,
  parameter int unsigned REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             flush,
  input  logic [NUM_REQ-1:0]                               req_valid,
  input  logic [NUM_REQ-1:0][`PHYSICAL_REG_NUM_WIDTH-1:0]  req_dst_reg,
  input  logic [NUM_REQ-1:0][`REG_VAL_WIDTH-1:0]           req_val,
  input  logic [NUM_REQ-1:0][`ROB_SIZE_WIDTH-1:0]          req_tag,
  output logic [NUM_REQ-1:0]                               req_ready,
  input  logic                                             cdb_ready,
  output logic                                             cdb_valid,
  output logic [`PHYSICAL_REG_NUM_WIDTH-1:0]               cdb_dst_reg,
  output logic [`REG_VAL_WIDTH-1:0]                        cdb_val,
  output logic [`ROB_SIZE_WIDTH-1:0]                       cdb_tag,
  output logic [REQ_IDX_W-1:0]                             cdb_src
);

  logic                               slot_free;
  logic [NUM_REQ-1:0]                 arb_req;
  logic [NUM_REQ-1:0]                 gnt;
  logic [REQ_IDX_W-1:0]               gnt_idx;
  logic                               gnt_any;

  logic [REQ_IDX_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic                               valid_q, valid_d;
  logic [`PHYSICAL_REG_NUM_WIDTH-1:0] dst_q, dst_d;
  logic [`REG_VAL_WIDTH-1:0]          val_q, val_d;
  logic [`ROB_SIZE_WIDTH-1:0]         tag_q, tag_d;
  logic [REQ_IDX_W-1:0]               src_q, src_d;

  // The slot accepts a new winner when empty or when it drains this cycle.
  assign slot_free = !valid_q || cdb_ready;
  assign arb_req   = (slot_free && !flush && !reset) ? req_valid : '0;

  rr_priority_picker #(
    .N  (NUM_REQ),
    .IW (REQ_IDX_W)
  ) u_picker (
    .req_i (arb_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign req_ready = gnt;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    valid_d  = valid_q;
    dst_d    = dst_q;
    val_d    = val_q;
    tag_d    = tag_q;
    src_d    = src_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (slot_free) begin
      if (gnt_any) begin
        valid_d  = 1'b1;
        dst_d    = req_dst_reg[gnt_idx];
        val_d    = req_val[gnt_idx];
        tag_d    = req_tag[gnt_idx];
        src_d    = gnt_idx;
        rr_ptr_d = REQ_IDX_W'(rr_wrap_inc(32'(gnt_idx), NUM_REQ));
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      valid_q  <= 1'b0;
      dst_q    <= '0;
      val_q    <= '0;
      tag_q    <= '0;
      src_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      dst_q    <= dst_d;
      val_q    <= val_d;
      tag_q    <= tag_d;
      src_q    <= src_d;
    end
  end

  assign cdb_valid   = valid_q;
  assign cdb_dst_reg = dst_q;
  assign cdb_val     = val_q;
  assign cdb_tag     = tag_q;
  assign cdb_src     = src_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// tb_cdb_arbiter : directed and random checks of cdb_arbiter against a model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int DW = 6;
  localparam int VW = 32;
  localparam int TW = 5;
  localparam int IW = 2;

  logic                  clk = 1'b0;
  logic                  reset, flush, cdb_ready;
  logic [N-1:0]          req_valid;
  logic [N-1:0][DW-1:0]  req_dst_reg;
  logic [N-1:0][VW-1:0]  req_val;
  logic [N-1:0][TW-1:0]  req_tag;
  logic [N-1:0]          req_ready;
  logic                  cdb_valid;
  logic [DW-1:0]         cdb_dst_reg;
  logic [VW-1:0]         cdb_val;
  logic [TW-1:0]         cdb_tag;
  logic [IW-1:0]         cdb_src;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(N), .REQ_IDX_W(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_dst_reg (req_dst_reg),
    .req_val     (req_val),
    .req_tag     (req_tag),
    .req_ready   (req_ready),
    .cdb_ready   (cdb_ready),
    .cdb_valid   (cdb_valid),
    .cdb_dst_reg (cdb_dst_reg),
    .cdb_val     (cdb_val),
    .cdb_tag     (cdb_tag),
    .cdb_src     (cdb_src)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pointer, broadcast slot, last grant.
  int            m_ptr    = 0;
  bit            m_valid  = 1'b0;
  logic [DW-1:0] m_dst    = '0;
  logic [VW-1:0] m_val    = '0;
  logic [TW-1:0] m_tag    = '0;
  int            m_src    = 0;
  int            last_gnt = -1;
  bit            started  = 1'b0;

  function automatic int model_grant();
    if (reset !== 1'b0 || flush !== 1'b0 || (m_valid && cdb_ready !== 1'b1)) return -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_valid[j] === 1'b1) return j;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    g = model_grant();
    last_gnt = g;
    if (reset === 1'b1) begin
      m_valid = 1'b0; m_ptr = 0; m_dst = '0; m_val = '0; m_tag = '0; m_src = 0;
    end else if (flush === 1'b1) begin
      m_valid = 1'b0;
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_dst   = req_dst_reg[g];
      m_val   = req_val[g];
      m_tag   = req_tag[g];
      m_src   = g;
      m_ptr   = (g + 1) % N;
    end else if (!m_valid || cdb_ready === 1'b1) begin
      m_valid = 1'b0;
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      int g;
      logic [N-1:0] em;
      g  = model_grant();
      em = '0;
      if (g >= 0) em[g] = 1'b1;
      chk("model req_ready", req_ready, em);
      chk("model cdb_valid", cdb_valid, m_valid);
      if (m_valid) begin
        chk("model cdb_dst", cdb_dst_reg, m_dst);
        chk("model cdb_val", cdb_val, m_val);
        chk("model cdb_tag", cdb_tag, m_tag);
        chk("model cdb_src", cdb_src, m_src);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input int dst, input logic [VW-1:0] val, input int tag);
    req_dst_reg[i] = DW'(dst);
    req_val[i]     = val;
    req_tag[i]     = TW'(tag);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; cdb_ready = 1'b1; req_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_req(i, 10 + i, 32'h100 + i, 1 + i);

    // Reset held two cycles with all requesters active.
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge clk);
      chk("reset req_ready", req_ready, 4'b0000);
      chk("reset cdb_valid", cdb_valid, 1'b0);
    end

    // Round-robin rotation with wrap.
    tick(); reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      logic [N-1:0] eg;
      eg = '0;
      eg[c % N] = 1'b1;
      @(negedge clk);
      chk("rr grant", req_ready, eg);
      if (c > 0) chk("rr cdb_src", cdb_src, c - 1);
      tick();
    end

    // Skip idle requesters: pointer is 1 here.
    req_valid = 4'b0001;
    @(negedge clk); chk("skip grant0", req_ready, 4'b0001);
    tick(); req_valid = 4'b1001;
    @(negedge clk); chk("skip grant3", req_ready, 4'b1000);
    chk("skip src0", cdb_src, 0);

    // Back-pressure holding a tag-5 broadcast.
    tick(); req_valid = 4'b0001; set_req(0, 20, 32'h55, 5);
    @(negedge clk); chk("bp load grant", req_ready, 4'b0001);
    tick(); req_valid = 4'b0100; set_req(2, 22, 32'h77, 7); cdb_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp req_ready", req_ready, 4'b0000);
      chk("bp cdb_valid", cdb_valid, 1'b1);
      chk("bp cdb_tag", cdb_tag, 5);
      tick();
    end
    cdb_ready = 1'b1;
    @(negedge clk);
    chk("bp release grant", req_ready, 4'b0100);
    chk("bp release tag", cdb_tag, 5);

    // Flush with req 1 pending.
    tick(); req_valid = 4'b0010; set_req(1, 21, 32'h66, 6); flush = 1'b1;
    @(negedge clk);
    chk("bp next tag", cdb_tag, 7);
    chk("bp next src", cdb_src, 2);
    chk("flush req_ready", req_ready, 4'b0000);
    tick(); flush = 1'b0;
    @(negedge clk);
    chk("flush cdb_valid", cdb_valid, 1'b0);
    chk("post-flush grant", req_ready, 4'b0010);

    // Payload integrity.
    tick(); req_valid = 4'b1000; set_req(3, 17, 32'hDEADBEEF, 9);
    @(negedge clk);
    chk("post-flush src", cdb_src, 1);
    chk("payload grant", req_ready, 4'b1000);
    tick(); req_valid = 4'b0000;
    @(negedge clk);
    chk("payload valid", cdb_valid, 1'b1);
    chk("payload dst", cdb_dst_reg, 17);
    chk("payload val", cdb_val, 32'hDEADBEEF);
    chk("payload tag", cdb_tag, 9);
    chk("payload src", cdb_src, 3);

    // Reset and flush together.
    tick(); reset = 1'b1; flush = 1'b1; req_valid = 4'b1111;
    @(negedge clk); chk("rst+flush req_ready", req_ready, 4'b0000);
    tick(); reset = 1'b0; flush = 1'b0; req_valid = 4'b0000;
    @(negedge clk);
    chk("rst+flush cdb_valid", cdb_valid, 1'b0);
    chk("rst cdb_src", cdb_src, 0);
    chk("rst cdb_tag", cdb_tag, 0);

    // Random traffic; requesters hold their payload until granted.
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset     = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 11) == 0);
      cdb_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_gnt == i) begin
          req_valid[i]   = $urandom_range(0, 1) == 1;
          req_dst_reg[i] = DW'($urandom);
          req_val[i]     = $urandom;
          req_tag[i]     = TW'($urandom);
        end
      end
    end

    tick();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the completed-result requests of all functional units (ALUs and memory units) onto the single common data bus (CDB). Grants one requester per cycle using round-robin priority and registers the winner into a broadcast stage. That stage drives the reservation-station units, the register status table and the ROB. Honours CDB back-pressure from the consumers.

## Interface
Parameters:
- NUM_REQ, 4: number of FU result requesters. Index 0..`NUM_OF_ALUS-1` are ALUs, the rest are MEM units. Minimum 2.
- REQ_IDX_W, $clog2(NUM_REQ): width of the requester index.

Ports:
- clk  in  1  system clock. Single clock domain.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of the broadcast stage (branch mispredict recovery).
- req_valid  in  NUM_REQ  FU i holds a completed result.
- req_dst_reg  in  NUM_REQ×`PHYSICAL_REG_NUM_WIDTH  destination physical register per requester.
- req_val  in  NUM_REQ×`REG_VAL_WIDTH  result value per requester.
- req_tag  in  NUM_REQ×`ROB_SIZE_WIDTH  ROB tag per requester.
- req_ready  out  NUM_REQ  one-hot grant. Requester i's result is accepted this cycle.
- cdb_ready  in  1  all CDB consumers can accept a broadcast.
- cdb_valid  out  1  broadcast valid.
- cdb_dst_reg  out  `PHYSICAL_REG_NUM_WIDTH  broadcast destination register.
- cdb_val  out  `REG_VAL_WIDTH  broadcast value.
- cdb_tag  out  `ROB_SIZE_WIDTH  broadcast ROB tag.
- cdb_src  out  REQ_IDX_W  index of the FU that produced the broadcast.

## Operation
- State:
  - rr_ptr (REQ_IDX_W): the highest-priority requester.
  - Broadcast register: cdb_valid plus payload.
- slot_free = !cdb_valid | cdb_ready. This is the output stage being empty, or being drained this cycle.
- Grant, combinational:
  - When slot_free and !flush, the first i with req_valid[i] searching rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ, gets req_ready[i]=1.
  - All other bits are 0. At most one bit of req_ready is set.
- On a grant to i:
  - The broadcast register loads req_* of i and cdb_src=i, with cdb_valid=1 at the next edge.
  - rr_ptr ← (i+1) mod NUM_REQ. The wrap is explicit, with no reliance on power-of-two NUM_REQ.
- slot_free with no request: cdb_valid←0. rr_ptr holds.
- !slot_free (cdb_valid=1, cdb_ready=0):
  - Payload and cdb_valid hold stable.
  - req_ready=0. rr_ptr holds.
- Requesters keep req_valid and payload stable until granted. The arbiter never drops an accepted result except on flush/reset.
- flush: cdb_valid←0 at the next edge and req_ready=0 that cycle. rr_ptr holds. Payload is don't-care.
- reset: cdb_valid←0, rr_ptr←0, payload←0, cdb_src←0. req_ready=0 during reset.
- reset and flush together: reset wins. Both produce cdb_valid=0.

## Timing
- Latency: grant in cycle N leads to a broadcast visible in cycle N+1.
- Throughput: one broadcast per cycle while cdb_ready=1.
- Back-to-back: with cdb_valid=1 and cdb_ready=1, a new grant occurs in the same cycle the old broadcast drains. There is no bubble.
- Fairness: a continuously requesting FU is granted within NUM_REQ grants.
- req_ready depends combinationally on req_valid, cdb_ready, flush and state. There is no path from req_* payload to req_ready.
- All outputs other than req_ready are registered.

## Structure
- The shared package (`defines`) provides the `REG_VAL_WIDTH`, `PHYSICAL_REG_NUM_WIDTH`, `ROB_SIZE_WIDTH`, `NUM_OF_ALUS` and `NUM_OF_MEM` macros.
- A cdb_entry_t struct {dst_reg, val, tag, src} is added to the shared package for reuse by the RS units and the ROB.
- One sub-module, rr_priority_picker (parameter N):
  - Inputs are a request vector and a pointer.
  - Outputs are a one-hot grant, a grant index and an any-grant flag.
  - It is instantiated once.

## Test plan
- Reset sequence: hold reset 2 cycles with req_valid=4'b1111. Required: req_ready=0 and cdb_valid=0 throughout. After release, the first grant goes to req 0.
- Round-robin rotation: req_valid=4'b1111 held and cdb_ready=1 for 4 cycles. Required: grants 0,1,2,3 and cdb_src 0,1,2,3 one cycle later. Cycle 5 grants 0 again, confirming wrap.
- Back-pressure: cdb_valid=1 with tag=5. Drive cdb_ready=0 for 3 cycles with req 2 pending. Required: outputs stable with tag=5 and req_ready=0. On the cycle cdb_ready returns to 1, req 2 is granted, and the next cycle shows its tag.
- Skip idle requesters: rr_ptr=1, req_valid=4'b0001. Required: grant to 0, then rr_ptr=1. Next req_valid=4'b1001 grants 3.
- Flush: flush asserted with cdb_valid=1 and req 1 pending. Required: req_ready=0 that cycle and cdb_valid=0 next cycle. The cycle after that, req 1 is granted.
- Payload integrity: req 3 with dst_reg=17, val=32'hDEADBEEF, tag=9. Required: the next cycle broadcasts exactly dst=17, val=DEADBEEF, tag=9, src=3.
